multi_capture: RTL and testbench

Parametrised multi-channel input capture front end for the angle-generator sensor inputs. Each channel has a two-flop synchroniser, a per-channel programmable integrating filter with hysteresis, single-cycle rise/fall strobes and an edge-mode-selected event latch. With timestamping compiled in, the event latch also holds a free-running timer snapshot. It sits between the raw crank/cam pins and the HWAG tooth-period logic and host status registers.

---
 rtl/capture_pkg.sv | 20 ++
 rtl/capture_channel.sv | 187 ++++++++++++++++++
 rtl/multi_capture.sv | 67 ++++++
 tb/tb_multi_capture.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/capture_pkg.sv
// ---------------------------------------------------------------------------
// capture_pkg
// Shared types and default widths for the multi-channel input capture block.
//   cap_mode_t     : per-channel edge select (none / rise / fall / both)
//   CAP_FW_DEFAULT : default filter counter / threshold width
//   CAP_TW_DEFAULT : default timer / timestamp width
// ---------------------------------------------------------------------------
package capture_pkg;

    typedef enum logic [1:0] {
        CAP_MODE_NONE = 2'b00,
        CAP_MODE_RISE = 2'b01,
        CAP_MODE_FALL = 2'b10,
        CAP_MODE_BOTH = 2'b11
    } cap_mode_t;

    localparam int CAP_FW_DEFAULT = 8;
    localparam int CAP_TW_DEFAULT = 24;

endpackage

// File: rtl/capture_channel.sv
// ---------------------------------------------------------------------------
// capture_channel
// One input-capture lane: two-flop synchroniser, integrating filter with
// hysteresis, registered rise/fall strobes and an edge-selected event latch.
// Build option: CAPTURE_TIMESTAMP_EN adds a TW-bit timer snapshot register;
// without it o_stamp is tied to zero and i_timer is ignored.
//
// Ports
//   clk, rst   : system clock, asynchronous active-high reset
//   i_ena      : enable; 0 freezes filter state and suppresses strobes
//   i_in       : raw asynchronous pin
//   i_thr      : filter threshold (0 = bypass)
//   i_mode     : edge select, see cap_mode_t
//   i_timer    : free-running timebase
//   i_ack      : event acknowledge / clear
//   o_filt     : filtered level
//   o_rise     : one-cycle strobe on filtered rising edge
//   o_fall     : one-cycle strobe on filtered falling edge
//   o_pend     : event pending
//   o_ovf      : an event arrived while one was already pending
//   o_stamp    : timer value captured with the pending event
// ---------------------------------------------------------------------------
module capture_channel
    import capture_pkg::*;
#(
    parameter int FW = CAP_FW_DEFAULT,
    parameter int TW = CAP_TW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_ena,
    input  logic          i_in,
    input  logic [FW-1:0] i_thr,
    input  logic [1:0]    i_mode,
    input  logic [TW-1:0] i_timer,
    input  logic          i_ack,
    output logic          o_filt,
    output logic          o_rise,
    output logic          o_fall,
    output logic          o_pend,
    output logic          o_ovf,
    output logic [TW-1:0] o_stamp
);

    logic          r_s1;
    logic          r_s2;
    logic [FW-1:0] r_cnt;
    logic          r_filt;
    logic          r_filtD;
    logic          r_rise;
    logic          r_fall;
    logic          r_pend;
    logic          r_ovf;

    logic [FW-1:0] w_cntNext;
    logic          w_filtNext;
    logic          w_riseDet;
    logic          w_fallDet;
    logic          w_selRise;
    logic          w_selFall;
    logic          w_event;
    logic          w_capture;
    cap_mode_t     w_mode;

    // The synchroniser is free-running so the pin is always tracked,
    // even while the channel is disabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= i_in;
            r_s2 <= r_s2 ^ (r_s1 ^ r_s2);
        end
    end

    // Filter next state. Counts are clamped to the current threshold so a
    // threshold reduction mid-count takes effect on the next enabled cycle.
    // The level only moves when the counter reaches an end stop with the
    // matching input value, which gives the hysteresis.
    always_comb begin
        w_cntNext  = r_cnt;
        w_filtNext = r_filt;
        if (i_thr == '0) begin
            w_cntNext  = '0;
            w_filtNext = r_s2;
        end else if (r_s2) begin
            w_cntNext = (r_cnt >= i_thr) ? i_thr : r_cnt + 1'b1;
            if (w_cntNext == i_thr) begin
                w_filtNext = 1'b1;
            end
        end else begin
            if (r_cnt == '0) begin
                w_cntNext = '0;
            end else if (r_cnt > i_thr) begin
                w_cntNext = i_thr - 1'b1;
            end else begin
                w_cntNext = r_cnt - 1'b1;
            end
            if (w_cntNext == '0) begin
                w_filtNext = 1'b0;
            end
        end
    end

    // Filter state only advances while enabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            r_filt <= 1'b0;
        end else if (i_ena) begin
            r_cnt  <= w_cntNext;
            r_filt <= w_filtNext;
        end
    end

    // Edge detection compares the filtered level with its delayed copy.
    // The delayed copy always follows, so an edge seen while disabled is
    // dropped rather than replayed on re-enable.
    assign w_riseDet = r_filt & ~r_filtD;
    assign w_fallDet = ~r_filt & r_filtD;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_filtD <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_filtD <= r_filt;
            r_rise  <= i_ena & w_riseDet;
            r_fall  <= i_ena & w_fallDet;
        end
    end

    assign w_mode    = cap_mode_t'(i_mode);
    assign w_selRise = (w_mode == CAP_MODE_RISE) || (w_mode == CAP_MODE_BOTH);
    assign w_selFall = (w_mode == CAP_MODE_FALL) || (w_mode == CAP_MODE_BOTH);
    assign w_event   = i_ena & ((w_riseDet & w_selRise) | (w_fallDet & w_selFall));
    // A new event is latched when nothing is pending or the host is clearing
    // in the same cycle; otherwise it is only recorded as an overflow.
    assign w_capture = w_event & (~r_pend | i_ack);

    // Event latch: ack is honoured regardless of enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend <= 1'b0;
            r_ovf  <= 1'b0;
        end else if (w_event) begin
            if (w_capture) begin
                r_pend <= 1'b1;
                r_ovf  <= 1'b0;
            end else begin
                r_ovf  <= 1'b1;
            end
        end else if (i_ack) begin
            r_pend <= 1'b0;
            r_ovf  <= 1'b0;
        end
    end

`ifdef CAPTURE_TIMESTAMP_EN
    logic [TW-1:0] r_stamp;

    // Snapshot is taken only for a latched event, so an overflow keeps the
    // time of the first event.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stamp <= '0;
        end else if (w_capture) begin
            r_stamp <= i_timer;
        end
    end

    assign o_stamp = r_stamp;
`else
    logic w_unusedTimer;
    assign w_unusedTimer = ^i_timer;
    assign o_stamp       = '0;
`endif

    assign o_filt = r_filt;
    assign o_rise = r_rise;
    assign o_fall = r_fall;
    assign o_pend = r_pend;
    assign o_ovf  = r_ovf;

endmodule

// File: rtl/multi_capture.sv
// ---------------------------------------------------------------------------
// multi_capture
// CH-channel input capture front end for the crank/cam sensor pins. Each
// channel is an independent capture_channel; this level only slices buses.
// Build option: CAPTURE_TIMESTAMP_EN enables per-channel timer snapshots.
//
// Ports
//   clk, rst : system clock, asynchronous active-high reset
//   ena      : global enable
//   in       : raw pins, one per channel
//   thr      : per-channel filter threshold, channel i at [i*FW +: FW]
//   mode     : per-channel edge select, channel i at [2*i +: 2]
//   timer    : free-running timebase
//   ack      : per-channel event acknowledge
//   filt     : filtered levels
//   rise     : rising-edge strobes
//   fall     : falling-edge strobes
//   pend     : event pending flags
//   ovf      : event overflow flags
//   stamp    : captured timer values, channel i at [i*TW +: TW]
// ---------------------------------------------------------------------------
module multi_capture
    import capture_pkg::*;
#(
    parameter int CH = 4,
    parameter int FW = CAP_FW_DEFAULT,
    parameter int TW = CAP_TW_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic [CH-1:0]    in,
    input  logic [CH*FW-1:0] thr,
    input  logic [2*CH-1:0]  mode,
    input  logic [TW-1:0]    timer,
    input  logic [CH-1:0]    ack,
    output logic [CH-1:0]    filt,
    output logic [CH-1:0]    rise,
    output logic [CH-1:0]    fall,
    output logic [CH-1:0]    pend,
    output logic [CH-1:0]    ovf,
    output logic [CH*TW-1:0] stamp
);

    for (genvar g = 0; g < CH; g++) begin : g_ch
        capture_channel #(
            .FW(FW),
            .TW(TW)
        ) u_channel (
            .clk    (clk),
            .rst    (rst),
            .i_ena  (ena),
            .i_in   (in[g]),
            .i_thr  (thr[g*FW +: FW]),
            .i_mode (mode[2*g +: 2]),
            .i_timer(timer),
            .i_ack  (ack[g]),
            .o_filt (filt[g]),
            .o_rise (rise[g]),
            .o_fall (fall[g]),
            .o_pend (pend[g]),
            .o_ovf  (ovf[g]),
            .o_stamp(stamp[g*TW +: TW])
        );
    end

endmodule

// File: tb/tb_multi_capture.sv
// ---------------------------------------------------------------------------
// tb_multi_capture
// Self-checking bench for multi_capture. Expected strobes (channel, kind,
// cycle) are queued when a pin step is driven and matched by a monitor when
// the DUT strobes. Directed checks cover filter hysteresis, bypass, event
// overflow/ack, enable freeze and asynchronous reset. Works with or without
// CAPTURE_TIMESTAMP_EN.
// ---------------------------------------------------------------------------
module tb_multi_capture;

   localparam int CH = 4;
   localparam int FW = 8;
   localparam int TW = 24;

   typedef struct {
      int ch;
      bit isRise;
      int cyc;
   } sbEntry_t;

   logic             clk = 1'b0;
   logic             rst;
   logic             ena;
   logic [CH-1:0]    pinIn;
   logic [CH*FW-1:0] thr;
   logic [2*CH-1:0]  mode;
   logic [TW-1:0]    timer;
   logic [CH-1:0]    ack;
   logic [CH-1:0]    filt;
   logic [CH-1:0]    rise;
   logic [CH-1:0]    fall;
   logic [CH-1:0]    pend;
   logic [CH-1:0]    ovf;
   logic [CH*TW-1:0] stamp;

   int       cyc = 0;
   int       checkCount = 0;
   int       passCount = 0;
   int       thrVal [CH] = '{4, 0, 2, 7};
   int       monIdx;
   sbEntry_t sbQ [$];

   multi_capture #(.CH(CH), .FW(FW), .TW(TW)) dut (
      .clk  (clk),
      .rst  (rst),
      .ena  (ena),
      .in   (pinIn),
      .thr  (thr),
      .mode (mode),
      .timer(timer),
      .ack  (ack),
      .filt (filt),
      .rise (rise),
      .fall (fall),
      .pend (pend),
      .ovf  (ovf),
      .stamp(stamp)
   );

   // Clock and a cycle counter that doubles as the timebase: during the
   // cycle following edge n the timer reads n.
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   assign timer = cyc[TW-1:0];

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      checkCount++;
      if (observed === expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: observed %0h expected %0h (cycle %0d)",
                  tag, observed, expected, cyc);
      end
   endtask

   function automatic logic [TW-1:0] stampOf(input int c);
      return stamp[c*TW +: TW];
   endfunction

   function automatic logic [TW-1:0] expStamp(input int v);
`ifdef CAPTURE_TIMESTAMP_EN
      return v[TW-1:0];
`else
      return '0;
`endif
   endfunction

   task automatic toCycle(input int n);
      while (cyc < n) @(negedge clk);
   endtask

   task automatic ackPulse(input logic [CH-1:0] mask);
      ack = mask;
      @(negedge clk);
      ack = '0;
   endtask

   // Drive one pin at the current falling edge and queue the strobe it must
   // produce. The value is stable before edge k = cyc+1; it reaches s2 after
   // edge k+1, filt changes after edge k+1+max(T,1) and the strobe is seen
   // one edge later. The event stamp is the cycle before the strobe.
   task automatic applyStimulus(input int ch, input logic val, output int strobeCyc);
      int tf;
      tf = (thrVal[ch] == 0) ? 1 : thrVal[ch];
      pinIn[ch] = val;
      strobeCyc = cyc + 1 + 2 + tf;
      sbQ.push_back('{ch: ch, isRise: val, cyc: strobeCyc});
   endtask

   // Strobe monitor: every strobe must match the oldest queued entry of its
   // channel in kind and cycle.
   always @(negedge clk) begin
      if (rst === 1'b0) begin
         for (int c = 0; c < CH; c++) begin
            if (rise[c] || fall[c]) begin
               checkOutput($sformatf("ch%0d rise&fall together", c), 64'(rise[c] & fall[c]), 64'd0);
               monIdx = -1;
               for (int j = 0; j < sbQ.size(); j++) begin
                  if (sbQ[j].ch == c) begin
                     monIdx = j;
                     break;
                  end
               end
               if (monIdx < 0) begin
                  checkOutput($sformatf("ch%0d unexpected strobe", c), 64'd1, 64'd0);
               end else begin
                  checkOutput($sformatf("ch%0d strobe cycle", c), 64'(cyc), 64'(sbQ[monIdx].cyc));
                  checkOutput($sformatf("ch%0d strobe kind", c), 64'(rise[c]), 64'(sbQ[monIdx].isRise));
                  sbQ.delete(monIdx);
               end
            end
         end
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int s, s1, s2, s3, c, k;
      int sArr [CH];
      int sFirst;
      int sMax;

      rst   = 1'b1;
      ena   = 1'b1;
      pinIn = '0;
      ack   = '0;
      mode  = 8'b11_10_11_01;
      for (int i = 0; i < CH; i++) thr[i*FW +: FW] = thrVal[i][FW-1:0];

      // ---------------- reset state ----------------
      repeat (3) @(negedge clk);
      checkOutput("reset filt", 64'(filt), 64'd0);
      checkOutput("reset rise", 64'(rise), 64'd0);
      checkOutput("reset fall", 64'(fall), 64'd0);
      checkOutput("reset pend", 64'(pend), 64'd0);
      checkOutput("reset ovf", 64'(ovf), 64'd0);
      checkOutput("reset stamp", 64'(stamp), 64'd0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // ---------------- A: T=4 step ----------------
      $display("[TB] step test, ch0 T=4");
      applyStimulus(0, 1'b1, s);
      toCycle(s - 2);
      checkOutput("A filt before latency", 64'(filt[0]), 64'd0);
      toCycle(s - 1);
      checkOutput("A filt at latency", 64'(filt[0]), 64'd1);
      toCycle(s);
      checkOutput("A pend", 64'(pend[0]), 64'd1);
      checkOutput("A ovf", 64'(ovf[0]), 64'd0);
      checkOutput("A stamp", 64'(stampOf(0)), 64'(expStamp(s - 1)));
      toCycle(s + 1);
      checkOutput("A rise single cycle", 64'(rise[0]), 64'd0);

      // ---------------- B: glitch rejection and hysteresis ----------------
      $display("[TB] glitch test, ch0 T=4");
      ackPulse(4'b0001);
      applyStimulus(0, 1'b0, s);
      toCycle(s + 2);
      c = cyc;
      pinIn[0] = 1'b1;
      toCycle(c + 3);
      pinIn[0] = 1'b0;
      toCycle(c + 6);
      checkOutput("B glitch filt mid", 64'(filt[0]), 64'd0);
      toCycle(c + 12);
      checkOutput("B glitch filt after", 64'(filt[0]), 64'd0);
      c = cyc;
      applyStimulus(0, 1'b1, s);
      toCycle(c + 10);
      pinIn[0] = 1'b0;
      toCycle(c + 13);
      pinIn[0] = 1'b1;
      toCycle(c + 15);
      checkOutput("B hysteresis filt during dip", 64'(filt[0]), 64'd1);
      toCycle(c + 22);
      checkOutput("B hysteresis filt after dip", 64'(filt[0]), 64'd1);

      // ---------------- C: T=0 bypass, mode both ----------------
      $display("[TB] bypass test, ch1 T=0");
      sFirst = 0;
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1, (i % 2) == 0, s);
         if (i == 0) sFirst = s;
         toCycle(s - 2);
         checkOutput("C filt before", 64'(filt[1]), 64'((i % 2) != 0));
         toCycle(s - 1);
         checkOutput("C filt after 2 cycles", 64'(filt[1]), 64'((i % 2) == 0));
         toCycle(s + 1);
      end
      checkOutput("C pend", 64'(pend[1]), 64'd1);
      checkOutput("C ovf", 64'(ovf[1]), 64'd1);
      checkOutput("C stamp keeps first", 64'(stampOf(1)), 64'(expStamp(sFirst - 1)));
      ackPulse(4'b0010);
      checkOutput("C ack clears pend", 64'(pend[1]), 64'd0);
      checkOutput("C ack clears ovf", 64'(ovf[1]), 64'd0);

      // ---------------- D: overflow and coincident ack ----------------
      $display("[TB] overflow test, ch0 mode rise");
      ackPulse(4'b0001);
      applyStimulus(0, 1'b0, s);
      toCycle(s + 1);
      applyStimulus(0, 1'b1, s1);
      toCycle(s1);
      checkOutput("D first pend", 64'(pend[0]), 64'd1);
      checkOutput("D first ovf", 64'(ovf[0]), 64'd0);
      checkOutput("D first stamp", 64'(stampOf(0)), 64'(expStamp(s1 - 1)));
      toCycle(s1 + 1);
      applyStimulus(0, 1'b0, s);
      toCycle(s + 1);
      applyStimulus(0, 1'b1, s2);
      toCycle(s2);
      checkOutput("D second ovf", 64'(ovf[0]), 64'd1);
      checkOutput("D second stamp holds", 64'(stampOf(0)), 64'(expStamp(s1 - 1)));
      toCycle(s2 + 1);
      applyStimulus(0, 1'b0, s);
      toCycle(s + 1);
      applyStimulus(0, 1'b1, s3);
      toCycle(s3 - 1);
      ack[0] = 1'b1;
      toCycle(s3);
      ack[0] = 1'b0;
      checkOutput("D third pend", 64'(pend[0]), 64'd1);
      checkOutput("D third ovf cleared", 64'(ovf[0]), 64'd0);
      checkOutput("D third stamp new", 64'(stampOf(0)), 64'(expStamp(s3 - 1)));

      // ---------------- E: enable freeze ----------------
      $display("[TB] enable test, ch0 falling with freeze");
      toCycle(s3 + 2);
      c = cyc;
      k = c + 1;
      pinIn[0] = 1'b0;
      sbQ.push_back('{ch: 0, isRise: 1'b0, cyc: k + 11});
      toCycle(k + 2);
      ena = 1'b0;
      toCycle(k + 3);
      ack[0] = 1'b1;
      toCycle(k + 4);
      ack[0] = 1'b0;
      checkOutput("E ack clears while disabled", 64'(pend[0]), 64'd0);
      toCycle(k + 7);
      checkOutput("E filt frozen", 64'(filt[0]), 64'd1);
      ena = 1'b1;
      toCycle(k + 9);
      checkOutput("E filt resumed count", 64'(filt[0]), 64'd1);
      toCycle(k + 10);
      checkOutput("E filt cleared", 64'(filt[0]), 64'd0);
      toCycle(k + 13);

      // ---------------- F: all channels simultaneous ----------------
      $display("[TB] multi-channel test");
      ackPulse(4'hF);
      sMax = 0;
      for (int i = 0; i < CH; i++) begin
         applyStimulus(i, 1'b1, sArr[i]);
         if (sArr[i] > sMax) sMax = sArr[i];
      end
      toCycle(sMax + 1);
      checkOutput("F rise filt", 64'(filt), 64'hF);
      checkOutput("F rise pend", 64'(pend), 64'b1011);
      checkOutput("F rise ovf", 64'(ovf), 64'd0);
      checkOutput("F ch0 stamp", 64'(stampOf(0)), 64'(expStamp(sArr[0] - 1)));
      checkOutput("F ch1 stamp", 64'(stampOf(1)), 64'(expStamp(sArr[1] - 1)));
      checkOutput("F ch3 stamp", 64'(stampOf(3)), 64'(expStamp(sArr[3] - 1)));
      checkOutput("F ch2 stamp untouched", 64'(stampOf(2)), 64'd0);
      sFirst = sArr[1];
      sMax = 0;
      for (int i = 0; i < CH; i++) begin
         applyStimulus(i, 1'b0, sArr[i]);
         if (sArr[i] > sMax) sMax = sArr[i];
      end
      toCycle(sMax + 1);
      checkOutput("F fall filt", 64'(filt), 64'd0);
      checkOutput("F fall pend", 64'(pend), 64'hF);
      checkOutput("F fall ovf", 64'(ovf), 64'b1010);
      checkOutput("F ch2 fall stamp", 64'(stampOf(2)), 64'(expStamp(sArr[2] - 1)));
      checkOutput("F ch1 stamp holds", 64'(stampOf(1)), 64'(expStamp(sFirst - 1)));

      // ---------------- G: asynchronous reset mid-count ----------------
      $display("[TB] async reset test");
      c = cyc;
      pinIn = 4'hF;
      toCycle(c + 3);
      checkOutput("G bypass filt before reset", 64'(filt[1]), 64'd1);
      #1 rst = 1'b1;
      #1;
      checkOutput("G reset filt", 64'(filt), 64'd0);
      checkOutput("G reset pend", 64'(pend), 64'd0);
      checkOutput("G reset ovf", 64'(ovf), 64'd0);
      checkOutput("G reset strobes", 64'({rise, fall}), 64'd0);
      checkOutput("G reset stamp", 64'(stamp), 64'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      sMax = 0;
      for (int i = 0; i < CH; i++) begin
         applyStimulus(i, 1'b1, sArr[i]);
         if (sArr[i] > sMax) sMax = sArr[i];
      end
      toCycle(sMax + 1);
      checkOutput("G post-reset filt", 64'(filt), 64'hF);
      checkOutput("G post-reset pend", 64'(pend), 64'b1011);
      checkOutput("G post-reset ch0 stamp", 64'(stampOf(0)), 64'(expStamp(sArr[0] - 1)));

      repeat (3) @(negedge clk);
      checkOutput("scoreboard empty", 64'(sbQ.size()), 64'd0);
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
